// File: rtl/imem_fetch_port.sv
// Instruction-side fetch port: word-organised instruction store with a loader write port
// and a registered F->D result {instr, pc, valid, adel} under stall/flush control.
module imem_fetch_port #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          AW          = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        req_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        ld_en_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        adel_o
);

  localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);

  // Offset is computed modulo 2^32, so addresses below the base wrap high and fall outside.
  function automatic logic addr_ok(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr[1:0] == 2'b00) && (off < WINDOW_BYTES);
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] addr);
    return AW'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_instr;
  logic [31:0]   r_pc;
  logic          r_valid;
  logic          r_adel;
  logic          w_fetch_ok;
  logic [AW-1:0] w_fetch_idx;
  logic          w_ld_ok;
  logic [AW-1:0] w_ld_idx;

  assign w_fetch_ok  = addr_ok(pc_i);
  assign w_fetch_idx = addr_idx(pc_i);
  assign w_ld_ok     = addr_ok(ld_addr_i);
  assign w_ld_idx    = addr_idx(ld_addr_i);

  // Loader write port; not gated by reset, stall or flush, illegal addresses are dropped.
  always_ff @(posedge clk) begin
    if (ld_en_i && w_ld_ok) begin
      r_mem[w_ld_idx] <= ld_data_i;
    end
  end

  // Fetch stage register; the store read sees pre-write contents on a same-word load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= 32'h0000_0000;
      r_pc    <= BASE_ADDR;
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
    end else if (flush_i) begin
      r_instr <= 32'h0000_0000;
      r_pc    <= pc_i;
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
    end else if (stall_i) begin
      r_instr <= r_instr;
      r_pc    <= r_pc;
      r_valid <= r_valid;
      r_adel  <= r_adel;
    end else if (req_i) begin
      r_pc    <= pc_i;
      r_valid <= 1'b1;
      if (w_fetch_ok) begin
        r_instr <= r_mem[w_fetch_idx];
        r_adel  <= 1'b0;
      end else begin
        r_instr <= 32'h0000_0000;
        r_adel  <= 1'b1;
      end
    end else begin
      r_instr <= 32'h0000_0000;
      r_pc    <= r_pc;
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
    end
  end

  assign instr_o = r_instr;
  assign pc_o    = r_pc;
  assign valid_o = r_valid;
  assign adel_o  = r_adel;

endmodule
